// File: rtl/mem_fifo_ctrl.sv
// FIFO controller around the dual-port write-first `mem` block. Slot DEPTH-1 absorbs
// idle-cycle writes. Define FIFO_LEVEL_EN to expose the occupancy as `level`.
module mem_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    mem_write_addr,
    output logic [WIDTH-1:0] mem_write_data,
    output logic [AW-1:0]    mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data
`ifdef FIFO_LEVEL_EN
    ,
    output logic [AW-1:0]    level
`endif
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 2);
    localparam logic [AW-1:0] SINK     = AW'(DEPTH - 1);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] count;
    logic [AW-1:0] count_next;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] x);
        return (x == LAST_PTR) ? '0 : x + AW'(1);
    endfunction

    assign in_ready = (count != SINK);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    assign out_data       = mem_read_data;
    assign mem_write_data = in_data;
    assign mem_write_addr = push ? tail : SINK;
    // Prefetch the next head so back-to-back pops see data without a bubble.
    assign mem_read_addr  = pop ? inc(head) : head;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + AW'(1);
        end else if (!push && pop) begin
            count_next = count - AW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) tail <= inc(tail);
            if (pop)  head <= inc(head);
            count     <= count_next;
            out_valid <= (count_next != '0);
        end
    end

`ifdef FIFO_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl: queue-based reference model plus directed
// scenarios, with a behavioural write-first `mem` attached to the controller.
module tb_mem_fifo_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CAP   = DEPTH - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    mem_write_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic [AW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;
`ifdef FIFO_LEVEL_EN
    logic [AW-1:0]    level;
`endif

    int checks = 0;
    int failures = 0;

    mem_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data)
`ifdef FIFO_LEVEL_EN
        ,
        .level          (level)
`endif
    );

    always #5 clk = ~clk;

    // Storage block: unconditional write, registered write-first read.
    logic [WIDTH-1:0] store [DEPTH];
    always @(posedge clk) begin
        store[mem_write_addr] <= mem_write_data;
        mem_read_data <= (mem_read_addr == mem_write_addr) ? mem_write_data : store[mem_read_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: entries held in a queue, pointer positions as plain modulo counters.
    logic [WIDTH-1:0] q[$];
    int               head_m = 0;
    int               tail_m = 0;
    logic [WIDTH-1:0] got[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            head_m = 0;
            tail_m = 0;
        end else begin
            automatic bit do_push = in_valid && (q.size() < CAP);
            automatic bit do_pop  = (q.size() != 0) && out_ready;
            if (do_pop) begin
                void'(q.pop_front());
                head_m = (head_m + 1) % CAP;
            end
            if (do_push) begin
                q.push_back(in_data);
                tail_m = (tail_m + 1) % CAP;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit exp_valid = (q.size() != 0);
            automatic bit exp_ready = (q.size() != CAP);
            automatic bit do_push   = in_valid && exp_ready;
            automatic bit do_pop    = exp_valid && out_ready;
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) check("out_data", 64'(out_data), 64'(q[0]));
            check("mem_write_addr", 64'(mem_write_addr), do_push ? 64'(tail_m) : 64'(CAP));
            check("mem_read_addr", 64'(mem_read_addr),
                  do_pop ? 64'((head_m + 1) % CAP) : 64'(head_m));
            check("mem_write_data", 64'(mem_write_data), 64'(in_data));
`ifdef FIFO_LEVEL_EN
            check("level", 64'(level), 64'(q.size()));
`endif
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < budget) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check("drain_done", 64'(out_valid), 64'(0));
    endtask

    initial begin
        int hi;
        do_reset();
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Single push into an empty FIFO.
        in_valid = 1'b1;
        in_data = 42;
        #1 check("push42_waddr", 64'(mem_write_addr), 64'(0));
        step();
        in_valid = 1'b0;
        #1;
        check("push42_valid", 64'(out_valid), 64'(1));
        check("push42_data", 64'(out_data), 64'(42));
        check("idle_waddr", 64'(mem_write_addr), 64'(255));
        step();
        check("idle_waddr2", 64'(mem_write_addr), 64'(255));
        drain(10);

        // Fill to capacity, reject an extra push, then push+pop while full.
        for (int i = 1; i <= CAP; i++) begin
            in_valid = 1'b1;
            in_data = i;
            step();
        end
        check("full_in_ready", 64'(in_ready), 64'(0));
        in_data = 999;
        step();
        check("full_hold", 64'(in_ready), 64'(0));
        got.delete();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("full_pop_ready", 64'(in_ready), 64'(1));
`ifdef FIFO_LEVEL_EN
        check("full_pop_level", 64'(level), 64'(254));
`endif
        drain(400);
        check("drain_count", 64'(got.size()), 64'(255));
        for (int i = 0; i < got.size(); i++) check("drain_order", 64'(got[i]), 64'(i + 1));

        // Continuous streaming, one push and one pop per cycle.
        got.delete();
        hi = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = i;
            step();
            if (out_valid) hi++;
        end
        in_valid = 1'b0;
        step();
        check("stream_valid_cycles", 64'(hi), 64'(100));
        check("stream_end_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b0;
        check("stream_count", 64'(got.size()), 64'(100));
        for (int i = 0; i < got.size(); i++) check("stream_order", 64'(got[i]), 64'(i));

        // Pointer wrap: advance both pointers to 254, then push three entries.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 254; i++) begin
            in_valid = 1'b1;
            in_data = 500 + i;
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("wrap_empty", 64'(out_valid), 64'(0));
        check("wrap_raddr", 64'(mem_read_addr), 64'(254));
        got.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 10 + i;
            #1 check("wrap_waddr", 64'(mem_write_addr), (i == 0) ? 64'(254) : 64'(i - 1));
            step();
        end
        in_valid = 1'b0;
        drain(10);
        check("wrap_count", 64'(got.size()), 64'(3));
        for (int i = 0; i < got.size(); i++) check("wrap_order", 64'(got[i]), 64'(10 + i));

        // Asynchronous reset in the middle of a cycle with 5 entries held.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 70 + i;
            step();
        end
        in_valid = 1'b0;
        check("hold5_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_in_ready", 64'(in_ready), 64'(1));
        step();
        #2 rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        in_data = 7;
        step();
        in_valid = 1'b0;
        #1;
        check("post_reset_valid", 64'(out_valid), 64'(1));
        check("post_reset_data", 64'(out_data), 64'(7));
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
